// File: rtl/axi_atop_pkg.sv
// rtl/axi_atop_pkg.sv - shared types, constants and helpers for the AXI ATOP resolver
package axi_atop_pkg;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [5:0] ATOP_NONE   = 6'b0;

  typedef enum logic [1:0] {IDLE, DRAIN, INJ_B, INJ_R} state_e;

  typedef struct packed {
    logic [ID_W-1:0]     aw_id;
    logic [ADDR_W-1:0]   aw_addr;
    logic [7:0]          aw_len;
    logic [5:0]          aw_atop;
    logic                aw_valid;
    logic [DATA_W-1:0]   w_data;
    logic [DATA_W/8-1:0] w_strb;
    logic                w_last;
    logic                w_valid;
    logic                b_ready;
    logic [ID_W-1:0]     ar_id;
    logic [ADDR_W-1:0]   ar_addr;
    logic [7:0]          ar_len;
    logic                ar_valid;
    logic                r_ready;
  } atop_req_t;

  typedef struct packed {
    logic                aw_ready;
    logic                w_ready;
    logic [ID_W-1:0]     b_id;
    logic [1:0]          b_resp;
    logic                b_valid;
    logic                ar_ready;
    logic [ID_W-1:0]     r_id;
    logic [DATA_W-1:0]   r_data;
    logic [1:0]          r_resp;
    logic                r_last;
    logic                r_valid;
  } atop_resp_t;

  // Only ATOPs with bit 5 set (AtomicLoad/Swap/Compare) return read data.
  function automatic logic atop_has_r(input logic [5:0] atop);
    return atop[5];
  endfunction

endpackage

// File: rtl/axi_atop_wcnt.sv
// rtl/axi_atop_wcnt.sv - outstanding passthrough write-burst counter with full/empty flags
module axi_atop_wcnt #(
  parameter int unsigned MaxCnt = 8,
  parameter int unsigned CntW   = $clog2(MaxCnt + 1)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_full,
  output logic o_empty
);

  logic [CntW-1:0] r_cnt;

  assign o_full  = (r_cnt == CntW'(MaxCnt));
  assign o_empty = (r_cnt == '0);

  // A simultaneous inc/dec nets to zero, even when empty or full.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec && !o_full) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (i_dec && !i_inc && !o_empty) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/axi_atop_resolver.sv
// rtl/axi_atop_resolver.sv - absorbs AXI ATOP bursts and answers them with SLVERR, passes all other traffic
// Optional rej_cnt_o statistics counter enabled by AXI_ATOP_RESOLVER_STATS_EN.
module axi_atop_resolver
  import axi_atop_pkg::*;
#(
  parameter type         axi_req_t  = atop_req_t,
  parameter type         axi_resp_t = atop_resp_t,
  parameter int unsigned MaxWTxns   = 8,
  parameter logic        AtopRespEn = 1'b1
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  axi_req_t  slv_req_i,
  output axi_resp_t slv_resp_o,
  output axi_req_t  mst_req_o,
  input  axi_resp_t mst_resp_i
`ifdef AXI_ATOP_RESOLVER_STATS_EN
  ,
  output logic [31:0] rej_cnt_o
`endif
);

  state_e                             r_state;
  logic [$bits(slv_req_i.aw_id)-1:0]  r_id;
  logic [7:0]                         r_len;
  logic [5:0]                         r_atop;
  logic [7:0]                         r_beat;
  logic                               r_busy;
  logic                               r_b_hold;

  logic w_idle, w_is_atop, w_full, w_empty;
  logic w_atop_rdy, w_atop_hs, w_aw_pass_hs;
  logic w_w_allow, w_w_dec;
  logic w_b_inj, w_b_inj_hs, w_r_inj, w_r_inj_hs, w_r_pass_hs;

  assign w_idle       = (r_state == IDLE);
  assign w_is_atop    = (slv_req_i.aw_atop != ATOP_NONE);
  assign w_atop_rdy   = w_idle && w_is_atop && w_empty;
  assign w_atop_hs    = w_atop_rdy && slv_req_i.aw_valid;
  assign w_aw_pass_hs = mst_req_o.aw_valid && mst_resp_i.aw_ready;
  assign w_w_allow    = !w_empty || w_aw_pass_hs;
  assign w_w_dec      = mst_req_o.w_valid && mst_resp_i.w_ready && slv_req_i.w_last;
  assign w_b_inj      = (r_state == INJ_B) && !r_b_hold;
  assign w_b_inj_hs   = w_b_inj && slv_req_i.b_ready;
  assign w_r_inj      = (r_state == INJ_R) && !r_busy;
  assign w_r_inj_hs   = w_r_inj && slv_req_i.r_ready;
  assign w_r_pass_hs  = mst_resp_i.r_valid && mst_req_o.r_ready;

  axi_atop_wcnt #(
    .MaxCnt (MaxWTxns)
  ) u_wcnt (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_inc   (w_aw_pass_hs),
    .i_dec   (w_w_dec),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    mst_req_o  = slv_req_i;
    slv_resp_o = mst_resp_i;

    mst_req_o.aw_valid  = slv_req_i.aw_valid && !w_is_atop && w_idle && !w_full;
    slv_resp_o.aw_ready = (w_idle && !w_is_atop && !w_full && mst_resp_i.aw_ready) || w_atop_rdy;

    // W beats without a matching accepted AW are held upstream.
    if (r_state == DRAIN) begin
      mst_req_o.w_valid  = 1'b0;
      slv_resp_o.w_ready = 1'b1;
    end else begin
      mst_req_o.w_valid  = slv_req_i.w_valid && w_w_allow;
      slv_resp_o.w_ready = mst_resp_i.w_ready && w_w_allow;
    end

    if (w_b_inj) begin
      mst_req_o.b_ready  = 1'b0;
      slv_resp_o.b_valid = 1'b1;
      slv_resp_o.b_id    = r_id;
      slv_resp_o.b_resp  = RESP_SLVERR;
    end

    if (w_r_inj) begin
      mst_req_o.r_ready  = 1'b0;
      slv_resp_o.r_valid = 1'b1;
      slv_resp_o.r_id    = r_id;
      slv_resp_o.r_data  = '0;
      slv_resp_o.r_resp  = RESP_SLVERR;
      slv_resp_o.r_last  = (r_beat == r_len);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_id     <= '0;
      r_len    <= '0;
      r_atop   <= '0;
      r_beat   <= '0;
      r_b_hold <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_atop_hs) begin
            r_id    <= slv_req_i.aw_id;
            r_len   <= slv_req_i.aw_len;
            r_atop  <= slv_req_i.aw_atop;
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (slv_req_i.w_valid && slv_req_i.w_last) begin
            // A downstream B already presented upstream keeps the channel one more cycle.
            r_b_hold <= mst_resp_i.b_valid && !slv_req_i.b_ready;
            r_state  <= INJ_B;
          end
        end
        INJ_B: begin
          if (r_b_hold) begin
            r_b_hold <= 1'b0;
          end else if (w_b_inj_hs) begin
            r_state <= (AtopRespEn && atop_has_r(r_atop)) ? INJ_R : IDLE;
          end
        end
        INJ_R: begin
          if (w_r_inj_hs) begin
            if (r_beat == r_len) begin
              r_beat  <= '0;
              r_state <= IDLE;
            end else begin
              r_beat <= r_beat + 8'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Injected R beats must not interleave into an in-flight downstream read burst.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_busy <= 1'b0;
    end else if (w_r_pass_hs) begin
      r_busy <= !mst_resp_i.r_last;
    end
  end

`ifdef AXI_ATOP_RESOLVER_STATS_EN
  logic [31:0] r_rej_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rej_cnt <= '0;
    end else if (w_atop_hs && (r_rej_cnt != 32'hFFFF_FFFF)) begin
      r_rej_cnt <= r_rej_cnt + 32'd1;
    end
  end

  assign rej_cnt_o = r_rej_cnt;
`endif

endmodule
